reg_file_we: RTL and testbench
==============================

# reg_file_we

Parameterised register file generalising the team's 8-bit register with active-low write enable: DEPTH entries of WIDTH bits, one write port with per-byte enables, and two independent registered read ports with write-first bypass. It sits next to datapath blocks that need a small, resettable set of configuration and state registers. Per-entry dirty flags tell downstream logic which entries have been written since reset.

## Interface
- WIDTH, 8, data width in bits; must be a multiple of 8 and at least 8.
- DEPTH, 4, number of entries; must be a power of 2 and at least 2. AW = $clog2(DEPTH).
- RST_VAL, 0, WIDTH-bit reset value of every entry and of both read outputs.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- we_n  in  1  write enable, active-low.
- wr_addr  in  AW  write entry index.
- be  in  WIDTH/8  byte enables for the write; bit k covers data bits [8k+7:8k].
- data_in  in  WIDTH  write data.
- rd_addr_a  in  AW  read port A entry index.
- rd_addr_b  in  AW  read port B entry index.
- data_out_a  out  WIDTH  registered read data, port A.
- data_out_b  out  WIDTH  registered read data, port B.
- dirty  out  DEPTH  bit i = 1 once entry i has had at least one byte written since reset.

## Operation
- Reset (rst_n = 0, asynchronous): every entry, data_out_a and data_out_b go to RST_VAL, and dirty goes to 0. All of them hold while rst_n is low, regardless of clk or other inputs.
- Write: on a rising edge with we_n = 0, each byte lane k with be[k] = 1 of entry wr_addr takes data_in lane k. Lanes with be[k] = 0 keep their value.
- When we_n = 0 and be is all zeros, no entry changes and dirty does not change.
- When we_n = 1, no entry changes, whatever be holds.
- Dirty: on a write with at least one be bit set, dirty[wr_addr] is set to 1. It stays at 1 until reset. Rewriting the same value still sets it.
- Read: on every rising edge, data_out_a loads entry rd_addr_a and data_out_b loads entry rd_addr_b. There is no read enable.
- Bypass (write-first): if a write and a read hit the same address on the same edge, that read port loads the merged post-write value, not the old one. Each port does this independently, so both ports can bypass on the same edge.
- Both ports may use the same address, and either may use the address being written. No conflicts are possible.
- All address values are legal because DEPTH is a power of 2.

## Timing
- Write latency: the entry updates at edge N. A read issued at edge N+1 without bypass returns the new value.
- Read latency: 1 cycle. An address presented before edge N appears on data_out after edge N and holds until edge N+1.
- Bypass latency: data written at edge N to address X appears at edge N on any port reading X in the same cycle.
- Reset release: the first rising edge with rst_n = 1 performs a normal write and read. Inputs are sampled at the rising edge only.
- Reset asserted mid-cycle: it overrides any write or read in progress, and the outputs change without waiting for a clock edge.

## Test plan
- Reset: WIDTH=16, DEPTH=4, RST_VAL=16'hA5A5. Hold rst_n=0 with we_n=0, be=2'b11, data_in=16'h1234 -> both outputs read 16'hA5A5 and dirty=4'b0000. After release, read all 4 entries -> each returns 16'hA5A5.
- Full write then read: write data 16'h1000+i to entry i, be=2'b11, for i=0..3, then read port A at 0..3 and port B at 3..0 -> each port returns the matching values one cycle after its address; dirty=4'b1111.
- Byte enables: write 16'hFFFF to entry 2, then 16'h00AB with be=2'b01 -> entry 2 reads 16'hFFAB. Then write 16'h1200 with be=2'b10 -> entry 2 reads 16'h12AB. Then we_n=0 with be=2'b00 on entry 1 -> entry 1 and dirty[1] are unchanged.
- we_n toggling: stream data_in=i for i=0..255 into entry 0 while we_n toggles every cycle for i=5..10 (as in the existing 8-bit register bench) -> entry 0 changes only on edges where we_n=0, and the read-back value always equals the last value written with we_n=0.
- Bypass: entry 3 holds 16'h0000. In one cycle write 16'hBEEF to entry 3 with be=2'b11 while rd_addr_a=rd_addr_b=3 -> both outputs show 16'hBEEF after that same edge. A partial write with be=2'b01 and data 16'h0011 over 16'hBEEF -> the bypassed output shows 16'hBE11.
- Reset mid-operation: write entry 1 = 16'h5555, then assert rst_n low between clock edges -> outputs show RST_VAL immediately, dirty=0, and entry 1 reads RST_VAL after release.

Source files
------------

// File: rtl/reg_file_we.sv
// Resettable register file: one byte-enabled write port (active-low enable) and
// two registered read ports with write-first bypass, plus per-entry dirty flags.
module reg_file_we #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we_n,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH/8-1:0]         be,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_a,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_b,
    output logic [WIDTH-1:0]           data_out_a,
    output logic [WIDTH-1:0]           data_out_b,
    output logic [DEPTH-1:0]           dirty
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_hit;
    logic [WIDTH-1:0] wr_merged;

    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_val,
        input logic [WIDTH-1:0] new_val,
        input logic [NB-1:0]    lane_en
    );
        logic [WIDTH-1:0] res;
        res = old_val;
        for (int k = 0; k < NB; k++) begin
            if (lane_en[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

    // Merged post-write entry value; also feeds the read bypass so both ports see write-first data.
    always_comb begin
        wr_hit    = !we_n && (be != '0);
        wr_merged = merge_bytes(mem[wr_addr], data_in, be);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
            dirty      <= '0;
            data_out_a <= RST_VAL;
            data_out_b <= RST_VAL;
        end else begin
            if (wr_hit) begin
                mem[wr_addr]   <= wr_merged;
                dirty[wr_addr] <= 1'b1;
            end
            data_out_a <= (wr_hit && (rd_addr_a == wr_addr)) ? wr_merged : mem[rd_addr_a];
            data_out_b <= (wr_hit && (rd_addr_b == wr_addr)) ? wr_merged : mem[rd_addr_b];
        end
    end

    logic unused_aw;
    assign unused_aw = (AW > 0) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_reg_file_we.sv
// Bench for reg_file_we (WIDTH=16, DEPTH=4, RST_VAL=16'hA5A5): directed scenarios
// plus randomized traffic checked against an array-based reference model.
module tb_reg_file_we;

    localparam int              WIDTH   = 16;
    localparam int              DEPTH   = 4;
    localparam logic [15:0]     RST_VAL = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        we_n = 1'b1;
    logic [1:0]  wr_addr = '0;
    logic [1:0]  be = '0;
    logic [15:0] data_in = '0;
    logic [1:0]  rd_addr_a = '0;
    logic [1:0]  rd_addr_b = '0;
    logic [15:0] data_out_a;
    logic [15:0] data_out_b;
    logic [3:0]  dirty;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_mem [DEPTH];
    logic [3:0]  m_dirty;
    logic [15:0] exp_a, exp_b;

    reg_file_we #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
        .clk(clk), .rst_n(rst_n), .we_n(we_n), .wr_addr(wr_addr), .be(be),
        .data_in(data_in), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b), .dirty(dirty)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = RST_VAL;
        m_dirty = '0;
        exp_a = RST_VAL;
        exp_b = RST_VAL;
    endtask

    // Apply one cycle of inputs, advance the model across the edge, return 1 time unit later.
    task automatic step(input logic wen, input logic [1:0] wa, input logic [1:0] b,
                        input logic [15:0] d, input logic [1:0] ra, input logic [1:0] rb);
        we_n = wen; wr_addr = wa; be = b; data_in = d; rd_addr_a = ra; rd_addr_b = rb;
        @(posedge clk);
        if (!wen) begin
            for (int k = 0; k < 2; k++)
                if (b[k]) m_mem[wa][8*k +: 8] = d[8*k +: 8];
            if (b != 2'b00) m_dirty[wa] = 1'b1;
        end
        exp_a = m_mem[ra];
        exp_b = m_mem[rb];
        #1;
    endtask

    task automatic test_reset();
        we_n = 1'b0; be = 2'b11; data_in = 16'h1234; wr_addr = 2'd1;
        rd_addr_a = 2'd1; rd_addr_b = 2'd2;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (data_out_a !== RST_VAL || data_out_b !== RST_VAL || dirty !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async: a=%h b=%h dirty=%b, want a=%h b=%h dirty=0000",
                     data_out_a, data_out_b, dirty, RST_VAL, RST_VAL);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (data_out_a !== RST_VAL || data_out_b !== RST_VAL || dirty !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold: a=%h b=%h dirty=%b, want a=%h b=%h dirty=0000",
                     data_out_a, data_out_b, dirty, RST_VAL, RST_VAL);
        end
        we_n = 1'b1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 2'd0, 2'b11, 16'h1234, 2'(i), 2'(3 - i));
            n_tests++;
            if (data_out_a !== RST_VAL || data_out_b !== RST_VAL) begin
                n_fail++;
                $display("FAIL reset_readback[%0d]: a=%h b=%h, want %h", i, data_out_a, data_out_b, RST_VAL);
            end
        end
        n_tests++;
        if (dirty !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_dirty_after_reads: got %b want 0000", dirty);
        end
    endtask

    task automatic test_full_write();
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 2'(i), 2'b11, 16'h1000 + 16'(i), 2'(i ^ 1), 2'(i ^ 2));
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 2'd0, 2'b00, 16'h0, 2'(i), 2'(3 - i));
            n_tests++;
            if (data_out_a !== 16'h1000 + 16'(i) || data_out_b !== 16'h1000 + 16'(3 - i)) begin
                n_fail++;
                $display("FAIL full_read[%0d]: a=%h b=%h, want a=%h b=%h", i, data_out_a, data_out_b,
                         16'h1000 + 16'(i), 16'h1000 + 16'(3 - i));
            end
        end
        n_tests++;
        if (dirty !== 4'b1111) begin
            n_fail++;
            $display("FAIL full_dirty: got %b want 1111", dirty);
        end
    endtask

    task automatic test_byte_enables();
        step(1'b0, 2'd2, 2'b11, 16'hFFFF, 2'd0, 2'd1);
        step(1'b0, 2'd2, 2'b01, 16'h00AB, 2'd0, 2'd1);
        step(1'b1, 2'd0, 2'b00, 16'h0, 2'd2, 2'd0);
        n_tests++;
        if (data_out_a !== 16'hFFAB) begin
            n_fail++;
            $display("FAIL be_low_lane: got %h want FFAB", data_out_a);
        end
        step(1'b0, 2'd2, 2'b10, 16'h1200, 2'd0, 2'd1);
        step(1'b1, 2'd0, 2'b00, 16'h0, 2'd0, 2'd2);
        n_tests++;
        if (data_out_b !== 16'h12AB) begin
            n_fail++;
            $display("FAIL be_high_lane: got %h want 12AB", data_out_b);
        end
        step(1'b0, 2'd1, 2'b00, 16'hDEAD, 2'd1, 2'd1);
        step(1'b1, 2'd0, 2'b00, 16'h0, 2'd1, 2'd2);
        n_tests++;
        if (data_out_a !== 16'h1001 || data_out_b !== 16'h12AB || dirty !== 4'b1111) begin
            n_fail++;
            $display("FAIL be_none: a=%h b=%h dirty=%b, want a=1001 b=12AB dirty=1111",
                     data_out_a, data_out_b, dirty);
        end
    endtask

    task automatic test_we_toggle();
        logic [15:0] last;
        int bad;
        logic wen;
        last = m_mem[0];
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            wen = (i >= 5 && i <= 10) ? i[0] : 1'b0;
            if (!wen) last = 16'(i);
            step(wen, 2'd0, 2'b11, 16'(i), 2'd0, 2'd0);
            n_tests++;
            if (data_out_a !== last || data_out_b !== last) begin
                n_fail++;
                $display("FAIL we_toggle[%0d]: a=%h b=%h want %h", i, data_out_a, data_out_b, last);
            end
        end
        step(1'b1, 2'd0, 2'b11, 16'h7777, 2'd0, 2'd3);
        n_tests++;
        if (data_out_a !== 16'h00FF) begin
            n_fail++;
            $display("FAIL we_toggle_final: got %h want 00FF", data_out_a);
        end
    endtask

    task automatic test_bypass();
        step(1'b0, 2'd3, 2'b11, 16'h0000, 2'd0, 2'd1);
        step(1'b0, 2'd3, 2'b11, 16'hBEEF, 2'd3, 2'd3);
        n_tests++;
        if (data_out_a !== 16'hBEEF || data_out_b !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL bypass_full: a=%h b=%h want BEEF", data_out_a, data_out_b);
        end
        step(1'b0, 2'd3, 2'b01, 16'h0011, 2'd3, 2'd0);
        n_tests++;
        if (data_out_a !== 16'hBE11 || data_out_b !== 16'h00FF) begin
            n_fail++;
            $display("FAIL bypass_partial: a=%h b=%h want a=BE11 b=00FF", data_out_a, data_out_b);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 2'd1, 2'b11, 16'h5555, 2'd1, 2'd1);
        n_tests++;
        if (data_out_a !== 16'h5555) begin
            n_fail++;
            $display("FAIL mid_prewrite: got %h want 5555", data_out_a);
        end
        we_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (data_out_a !== RST_VAL || data_out_b !== RST_VAL || dirty !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_async: a=%h b=%h dirty=%b, want %h %h 0000",
                     data_out_a, data_out_b, dirty, RST_VAL, RST_VAL);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        step(1'b0, 2'd2, 2'b00, 16'hFFFF, 2'd1, 2'd2);
        n_tests++;
        if (data_out_a !== RST_VAL || data_out_b !== RST_VAL || dirty !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_after_release: a=%h b=%h dirty=%b, want %h %h 0000",
                     data_out_a, data_out_b, dirty, RST_VAL, RST_VAL);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 16'($urandom),
                 2'($urandom), 2'($urandom));
            n_tests++;
            if (data_out_a !== exp_a || data_out_b !== exp_b || dirty !== m_dirty) begin
                n_fail++;
                $display("FAIL random[%0d]: a=%h b=%h dirty=%b, want a=%h b=%h dirty=%b",
                         i, data_out_a, data_out_b, dirty, exp_a, exp_b, m_dirty);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_write();
        test_byte_enables();
        test_we_toggle();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
